uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART serial receiver with a configurable oversampling ratio. It detects a start bit on RX_IN, majority-samples each bit mid-period, deserialises DATA_WIDTH bits LSB-first, and optionally checks even/odd parity. It checks the stop bit and pulses data_valid with the received word. It sits between the asynchronous serial pin (already synchronised upstream) and the system's byte-level consumer.

Parameters:
DATA_WIDTH, 8, number of data bits per frame and width of P_DATA.

Ports:
CLK  in  1  oversampling clock; one bit period = Prescale CLK cycles.
RST  in  1  synchronous, active-high reset.
RX_IN  in  1  serial line; idle high.
Prescale  in  6  oversampling ratio; supported values 8, 16, 32.
PAR_EN  in  1  1 = a parity bit follows the data bits.
PAR_TYP  in  1  0 = even parity, 1 = odd parity.
P_DATA  out  DATA_WIDTH  last good received word.
data_valid  out  1  one-cycle pulse when P_DATA is updated with a good frame.
parity_error  out  1  one-cycle pulse, frame dropped because of a parity mismatch.
framing_error  out  1  one-cycle pulse, frame dropped because the stop bit sampled 0.

Behaviour:
- Frame format: start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1). Each bit lasts exactly Prescale CLK cycles.
- Expected parity bit: even = XOR of the data bits; odd = XNOR of the data bits.
- Reset (RST=1 at a CLK edge): state IDLE, all counters 0, P_DATA=0, data_valid=0, parity_error=0, framing_error=0. A reset mid-frame aborts the frame with no output pulse.
- Counters:
  - edge_cnt (6 bits) counts 0..Prescale-1 within each bit and wraps to 0 at Prescale-1.
  - bit_cnt counts the data bits.
- Sampling:
  - RX_IN is captured at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1.
  - The bit value is the majority of the three samples, resolved at edge_cnt = Prescale/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If RX_IN=0, that cycle counts as edge 0 of the start bit. Go to START with edge_cnt=1.
  - Otherwise stay in IDLE.
- START:
  - If the resolved start sample is 1 (glitch), return to IDLE immediately. No error pulse.
  - Otherwise go to DATA at the end of the bit period (edge_cnt wrap).
- DATA:
  - Shift the resolved sample into the shift register at bit position bit_cnt.
  - After DATA_WIDTH bits, at the bit-period end, go to PARITY if PAR_EN=1, else go to STOP.
- PARITY: capture the resolved sample and compare it with the expected parity computed from the shift register. Go to STOP at the bit-period end.
- STOP: at edge_cnt = Prescale-1 (last cycle of the stop bit), evaluate the frame:
  - Stop sample 1 and no parity mismatch: load P_DATA from the shift register and assert data_valid for exactly that one cycle.
  - Parity mismatch: parity_error pulses for that one cycle; P_DATA keeps its old value.
  - Stop sample 0: framing_error pulses for that one cycle; P_DATA keeps its old value. Both error pulses may assert together.
  - Next state is always IDLE.
- Back-to-back frames: a start edge arriving in the cycle right after STOP is detected in IDLE normally, with no dead time beyond that cycle.
- P_DATA holds its value between frames.
- Configuration: Prescale, PAR_EN and PAR_TYP are sampled continuously. They may change only while in IDLE; behaviour for a change mid-frame is undefined. Prescale values other than even values ≥ 6 are unsupported.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Parity-type constants PAR_EVEN=0 and PAR_ODD=1.
- One sub-module, uart_rx_sampler:
  - Inputs: CLK, RST, RX_IN, Prescale, edge_cnt.
  - Output: majority-voted sampled_bit.
- The FSM, counters, deserialiser and checkers stay in uart_rx.

Test Plan:
1. Prescale=32, PAR_EN=1, PAR_TYP=1; send 0xBB with parity bit 1 -> exactly one data_valid pulse; P_DATA=0xBB; no error pulses.
2. Prescale=32, PAR_EN=1, PAR_TYP=0; send 0x8D. Then Prescale=32, PAR_EN=0; send 0x9F. Expected: data_valid with P_DATA=0x8D, then data_valid with P_DATA=0x9F.
3. Prescale=16:
   - PAR_EN=1, PAR_TYP=1, send 0xB4 -> data_valid, P_DATA=0xB4.
   - PAR_EN=1, PAR_TYP=0, send 0xBB -> data_valid, P_DATA=0xBB.
   - PAR_EN=0, send 0x2F -> data_valid, P_DATA=0x2F.
4. Prescale=8:
   - PAR_EN=1, PAR_TYP=1, send 0xC2 -> data_valid, P_DATA=0xC2.
   - PAR_EN=1, PAR_TYP=0, send 0xAB -> data_valid, P_DATA=0xAB.
   - PAR_EN=0, send 0x12 -> data_valid, P_DATA=0x12.
5. Prescale=16, PAR_EN=1, PAR_TYP=1:
   - Send 0xBB with parity bit 0 -> parity_error pulse, no data_valid, P_DATA unchanged.
   - Send 0x55 with stop bit 0 -> framing_error pulse, no data_valid.
6. Line and reset robustness:
   - RX_IN low for 2 cycles at Prescale=16 -> FSM returns to IDLE, no outputs.
   - RST=1 in the middle of the DATA state -> all outputs 0; the next clean frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, parity-type
// constants and small bit-level helpers used by the receiver and its sampler.
package uart_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Parity type selector values for PAR_TYP.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Width of the oversampling ratio and of the per-bit edge counter.
  localparam int PRESCALE_W = 6;

  // Two-out-of-three vote used to reject a single noisy sample.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Mid-bit sample position: Prescale/2, computed without a divider.
  function automatic logic [PRESCALE_W-1:0] half_period(input logic [PRESCALE_W-1:0] prescale);
    return {1'b0, prescale[PRESCALE_W-1:1]};
  endfunction

endpackage : uart_pkg

// File: rtl/uart_rx_sampler.sv
// Mid-bit majority sampler. Captures RX_IN one cycle before and at the bit
// centre, then votes those two samples together with the live line value one
// cycle after the centre. sampled_bit is meaningful only in the cycle where
// edge_cnt == Prescale/2 + 1.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  sampled_bit
);

  logic                  early_q;
  logic                  centre_q;
  logic [PRESCALE_W-1:0] half;

  assign half = half_period(Prescale);

  // Hold the two earlier samples of the current bit until the vote cycle.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its inputs, independent of block order.
    if (RST) begin
      early_q  <= 1'b0;
      centre_q <= 1'b0;
    end else begin
      if (edge_cnt == half - 6'd1) early_q  <= RX_IN;
      if (edge_cnt == half)        centre_q <= RX_IN;
    end
  end

  // Third sample is the live line value, so the vote resolves at centre + 1.
  assign sampled_bit = majority3(early_q, centre_q, RX_IN);

endmodule : uart_rx_sampler

// File: rtl/uart_rx.sv
// UART receiver: start-bit detection, oversampled mid-bit majority sampling,
// LSB-first deserialisation, optional even/odd parity check and stop-bit
// check. A good frame updates P_DATA and pulses data_valid; a bad frame is
// dropped and reported through one-cycle parity_error / framing_error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  framing_error
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  rx_state_e             state_q,     state_d;
  logic [PRESCALE_W-1:0] edge_cnt_q,  edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q,     shift_d;
  logic                  par_err_q,   par_err_d;
  logic                  stop_bit_q,  stop_bit_d;
  logic [DATA_WIDTH-1:0] p_data_q,    p_data_d;
  logic                  valid_q,     valid_d;
  logic                  par_pulse_q, par_pulse_d;
  logic                  frm_pulse_q, frm_pulse_d;

  logic                  sampled_bit;
  logic                  edge_last;
  logic                  sample_pt;
  logic [PRESCALE_W-1:0] edge_next;
  logic                  exp_parity;

  uart_rx_sampler u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .edge_cnt    (edge_cnt_q),
    .sampled_bit (sampled_bit)
  );

  // Bit-period timing derived from the current edge count.
  assign edge_last = (edge_cnt_q == Prescale - 6'd1);
  assign sample_pt = (edge_cnt_q == half_period(Prescale) + 6'd1);
  assign edge_next = edge_last ? '0 : edge_cnt_q + 6'd1;

  // Parity the transmitter should have sent for the deserialised word.
  always_comb begin
    exp_parity = ^shift_q;
    case (PAR_TYP)
      PAR_EVEN: exp_parity = ^shift_q;
      PAR_ODD:  exp_parity = ~^shift_q;
      default:  exp_parity = ^shift_q;
    endcase
  end

  // Next-state, counter, deserialiser and frame-check logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    edge_cnt_d  = edge_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    stop_bit_d  = stop_bit_q;
    p_data_d    = p_data_q;
    valid_d     = 1'b0;
    par_pulse_d = 1'b0;
    frm_pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        par_err_d  = 1'b0;
        stop_bit_d = 1'b0;
        // The first low cycle is edge 0 of the start bit.
        if (!RX_IN) begin
          state_d    = START;
          edge_cnt_d = 6'd1;
        end
      end

      START: begin
        edge_cnt_d = edge_next;
        if (sample_pt && sampled_bit) begin
          // Line went back high before mid-bit: a glitch, not a frame.
          state_d    = IDLE;
          edge_cnt_d = '0;
        end else if (edge_last) begin
          state_d = DATA;
        end
      end

      DATA: begin
        edge_cnt_d = edge_next;
        if (sample_pt) shift_d[bit_cnt_q] = sampled_bit;
        if (edge_last) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = PAR_EN ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      PARITY: begin
        edge_cnt_d = edge_next;
        if (sample_pt) par_err_d = (sampled_bit != exp_parity);
        if (edge_last) state_d = STOP;
      end

      STOP: begin
        edge_cnt_d = edge_next;
        if (sample_pt) stop_bit_d = sampled_bit;
        // The stop sample was latched earlier in this bit, so the verdict
        // can be issued on the final cycle of the stop bit.
        if (edge_last) begin
          state_d     = IDLE;
          par_pulse_d = par_err_q;
          frm_pulse_d = ~stop_bit_q;
          if (stop_bit_q && !par_err_q) begin
            p_data_d = shift_q;
            valid_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  // State register; a synchronous reset aborts any frame in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      edge_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      // NOTE: the shift register is reset along with the control state so a
      // frame aborted by reset never leaves stale bits visible afterwards.
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      stop_bit_q  <= 1'b0;
      p_data_q    <= '0;
      valid_q     <= 1'b0;
      par_pulse_q <= 1'b0;
      frm_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_cnt_q  <= edge_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      stop_bit_q  <= stop_bit_d;
      p_data_q    <= p_data_d;
      valid_q     <= valid_d;
      par_pulse_q <= par_pulse_d;
      frm_pulse_q <= frm_pulse_d;
    end
  end

  assign P_DATA        = p_data_q;
  assign data_valid    = valid_q;
  assign parity_error  = par_pulse_q;
  assign framing_error = frm_pulse_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames at every supported
// oversampling ratio, error frames, glitch and reset robustness, then a
// randomized run, all compared with a frame-level reference model.
module tb_uart_rx;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic [5:0]    Prescale;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          parity_error;
  logic          framing_error;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed pulse activity, collected on falling edges.
  int            dv_cnt = 0;
  int            pe_cnt = 0;
  int            fe_cnt = 0;
  logic [DW-1:0] got_q[$];

  // Reference model expectations.
  int            exp_dv = 0;
  int            exp_pe = 0;
  int            exp_fe = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_pdata = '0;

  always #5 CLK = ~CLK;

  uart_rx #(.DATA_WIDTH(DW)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .RX_IN         (RX_IN),
    .Prescale      (Prescale),
    .PAR_EN        (PAR_EN),
    .PAR_TYP       (PAR_TYP),
    .P_DATA        (P_DATA),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error)
  );

  // Monitor: record every output pulse and the word delivered with data_valid.
  always @(negedge CLK) begin
    if (data_valid) begin
      dv_cnt++;
      got_q.push_back(P_DATA);
    end
    if (parity_error)  pe_cnt++;
    if (framing_error) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks; inputs change 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_counts();
    dv_cnt = 0; pe_cnt = 0; fe_cnt = 0; got_q.delete();
    exp_dv = 0; exp_pe = 0; exp_fe = 0; exp_q.delete();
  endtask

  // Drive one frame on the line and update the model from the bits sent.
  task automatic send_frame(input logic [DW-1:0] d, input int presc, input bit pen,
                            input bit ptyp, input bit flip_par, input bit bad_stop,
                            input int gap);
    bit frame[$];
    bit ref_par;
    bit par_ok;
    Prescale = 6'(presc);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    // Even parity bit = XOR of data; odd parity bit = its complement.
    ref_par = ptyp ? ~(^d) : ^d;
    frame.push_back(1'b0);
    for (int i = 0; i < DW; i++) frame.push_back(d[i]);
    if (pen) frame.push_back(ref_par ^ flip_par);
    frame.push_back(!bad_stop);
    foreach (frame[i]) begin
      RX_IN = frame[i];
      tick(presc);
    end
    RX_IN = 1'b1;
    tick(gap);
    par_ok = !pen || (frame[DW + 1] == ref_par);
    if (par_ok && !bad_stop) begin
      exp_dv++;
      exp_q.push_back(d);
      exp_pdata = d;
    end
    if (!par_ok)  exp_pe++;
    if (bad_stop) exp_fe++;
  endtask

  // Compare everything observed since the last clear_counts with the model.
  task automatic check_frames(input string tag);
    check({tag, ".dv_cnt"}, 32'(dv_cnt), 32'(exp_dv));
    check({tag, ".pe_cnt"}, 32'(pe_cnt), 32'(exp_pe));
    check({tag, ".fe_cnt"}, 32'(fe_cnt), 32'(exp_fe));
    if (got_q.size() == exp_q.size()) begin
      foreach (exp_q[i]) check($sformatf("%s.word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    check({tag, ".P_DATA"}, 32'(P_DATA), 32'(exp_pdata));
    clear_counts();
  endtask

  initial begin
    int presc_tab[3];
    presc_tab[0] = 8; presc_tab[1] = 16; presc_tab[2] = 32;

    // Reset state.
    RST = 1'b1; RX_IN = 1'b1; Prescale = 6'd32; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    tick(3);
    check("reset.P_DATA",     32'(P_DATA), 32'h0);
    check("reset.data_valid", 32'(data_valid), 32'h0);
    check("reset.par_err",    32'(parity_error), 32'h0);
    check("reset.frm_err",    32'(framing_error), 32'h0);
    RST = 1'b0;
    tick(4);
    clear_counts();

    // Prescale 32.
    send_frame(8'hBB, 32, 1, 1, 0, 0, 64); check_frames("p32_odd_BB");
    send_frame(8'h8D, 32, 1, 0, 0, 0, 64);
    send_frame(8'h9F, 32, 0, 0, 0, 0, 64); check_frames("p32_8D_9F");

    // Prescale 16.
    send_frame(8'hB4, 16, 1, 1, 0, 0, 32); check_frames("p16_odd_B4");
    send_frame(8'hBB, 16, 1, 0, 0, 0, 32); check_frames("p16_even_BB");
    send_frame(8'h2F, 16, 0, 0, 0, 0, 32); check_frames("p16_nopar_2F");

    // Prescale 8.
    send_frame(8'hC2, 8, 1, 1, 0, 0, 16); check_frames("p8_odd_C2");
    send_frame(8'hAB, 8, 1, 0, 0, 0, 16); check_frames("p8_even_AB");
    send_frame(8'h12, 8, 0, 0, 0, 0, 16); check_frames("p8_nopar_12");

    // Error frames: bad parity, then bad stop bit; P_DATA must hold.
    send_frame(8'hBB, 16, 1, 1, 1, 0, 32); check_frames("p16_bad_parity");
    send_frame(8'h55, 16, 1, 1, 0, 1, 32); check_frames("p16_bad_stop");
    send_frame(8'hE7, 8, 1, 0, 1, 1, 16);  check_frames("p8_both_errors");

    // Back-to-back frames with no idle gap between them.
    send_frame(8'h5A, 16, 1, 0, 0, 0, 0);
    send_frame(8'hC3, 16, 1, 0, 0, 0, 32); check_frames("p16_back_to_back");

    // Start glitch: line low for 2 cycles only, then a clean frame.
    Prescale = 6'd16; PAR_EN = 1'b0;
    RX_IN = 1'b0; tick(2);
    RX_IN = 1'b1; tick(48);
    check_frames("glitch_no_output");
    send_frame(8'h96, 16, 0, 0, 0, 0, 32); check_frames("after_glitch");

    // Reset in the middle of the data bits.
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    RX_IN = 1'b0; tick(16);
    RX_IN = 1'b1; tick(16);
    RX_IN = 1'b0; tick(24);
    RST = 1'b1; RX_IN = 1'b1;
    tick(1);
    exp_pdata = '0;
    check("midreset.P_DATA",     32'(P_DATA), 32'h0);
    check("midreset.data_valid", 32'(data_valid), 32'h0);
    check("midreset.par_err",    32'(parity_error), 32'h0);
    check("midreset.frm_err",    32'(framing_error), 32'h0);
    RST = 1'b0;
    tick(200);
    check_frames("midreset_quiet");
    send_frame(8'h3C, 16, 1, 0, 0, 0, 32); check_frames("after_reset_3C");

    // Randomized frames with occasional injected errors.
    for (int n = 0; n < 24; n++) begin
      logic [DW-1:0] d;
      int presc;
      bit pen, ptyp, fp, bs;
      d     = DW'($urandom);
      presc = presc_tab[$urandom_range(0, 2)];
      pen   = 1'($urandom);
      ptyp  = 1'($urandom);
      fp    = pen && ($urandom_range(0, 3) == 0);
      bs    = ($urandom_range(0, 4) == 0);
      send_frame(d, presc, pen, ptyp, fp, bs, ($urandom_range(0, 1) == 0) ? 0 : 2 * presc);
      if (n % 3 == 2) begin
        tick(2 * presc);
        check_frames($sformatf("rand%0d", n));
      end
    end
    tick(64);
    check_frames("rand_tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_rx
